irrigation_state_controller: RTL

Finite-state controller that generates the 2-bit `state` code driving the water-box stage: it selects fill versus drain and the drain rate (standby, sprinkler, drip). It consumes the encoded tank level `water_box` fed back from the water-box stage plus two field sensors. It filters those inputs, enforces a minimum dwell per irrigation state, and raises an alarm when irrigation is demanded while the tank is refilling.

---
 rtl/irrigation_state_controller_if.sv | 20 ++
 rtl/irrigation_state_controller.sv | 129 ++++++++++++
 2 files changed

// File: rtl/irrigation_state_controller_if.sv
// Sensor/level inputs and state/alarm outputs of the irrigation state controller.
// The master side drives the sensors and level; the slave side is the controller.
interface irrigation_state_controller_if;
    logic [1:0] water_box;
    logic       soil_dry;
    logic       air_dry;
    logic [1:0] state;
    logic       alarm;
    logic       dwell_done;

    modport master (
        output water_box, soil_dry, air_dry,
        input  state, alarm, dwell_done
    );

    modport slave (
        input  water_box, soil_dry, air_dry,
        output state, alarm, dwell_done
    );
endinterface

// File: rtl/irrigation_state_controller.sv
// Fill/drain FSM for the water-box stage: input sync, minimum dwell timer, demand-while-filling alarm.
// Define IRRIGATION_SENSOR_DEBOUNCE_EN to add a per-sensor debounce filter.
module irrigation_state_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned MIN_DWELL       = 16
) (
    input logic                          clock,
    input logic                          reset,
    irrigation_state_controller_if.slave bus
);
    typedef enum logic [1:0] {
        FILL     = 2'b00,
        STANDBY  = 2'b01,
        SPRINKLE = 2'b10,
        DRIP     = 2'b11
    } state_e;

    localparam logic [7:0] DWELL_MAX = 8'(MIN_DWELL);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || MIN_DWELL < 1 || MIN_DWELL > 255) begin : g_param_check
        $error("irrigation_state_controller: parameter out of range 1..255");
    end

    logic [1:0] wb_s1_q, wb_s2_q;
    logic [1:0] soil_sync_q, air_sync_q;   // bit 1 is the synchronized sample
    logic       soil_f, air_f;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_s1_q     <= '0;
            wb_s2_q     <= '0;
            soil_sync_q <= '0;
            air_sync_q  <= '0;
        end else begin
            wb_s1_q     <= bus.water_box;
            wb_s2_q     <= wb_s1_q;
            soil_sync_q <= {soil_sync_q[0], bus.soil_dry};
            air_sync_q  <= {air_sync_q[0], bus.air_dry};
        end
    end

`ifdef IRRIGATION_SENSOR_DEBOUNCE_EN
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] soil_cnt_q, air_cnt_q;
    logic       soil_f_q, air_f_q;

    // Sensors are single bits, so the pending value is always the complement of the filtered one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            soil_cnt_q <= '0;
            air_cnt_q  <= '0;
            soil_f_q   <= 1'b0;
            air_f_q    <= 1'b0;
        end else begin
            if (soil_sync_q[1] != soil_f_q) begin
                if (soil_cnt_q == DEB_LAST) begin
                    soil_f_q   <= soil_sync_q[1];
                    soil_cnt_q <= '0;
                end else begin
                    soil_cnt_q <= soil_cnt_q + 8'd1;
                end
            end else begin
                soil_cnt_q <= '0;
            end
            if (air_sync_q[1] != air_f_q) begin
                if (air_cnt_q == DEB_LAST) begin
                    air_f_q   <= air_sync_q[1];
                    air_cnt_q <= '0;
                end else begin
                    air_cnt_q <= air_cnt_q + 8'd1;
                end
            end else begin
                air_cnt_q <= '0;
            end
        end
    end

    assign soil_f = soil_f_q;
    assign air_f  = air_f_q;
`else
    assign soil_f = soil_sync_q[1];
    assign air_f  = air_sync_q[1];
`endif

    state_e     state_q, state_d;
    logic [7:0] dwell_q, dwell_d;
    logic       alarm_q, dwell_done_q;

    // Empty tank overrides every sensor condition; full tank only matters while filling.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (wb_s2_q == 2'b11) state_d = STANDBY;
            STANDBY: begin
                if (wb_s2_q == 2'b00)            state_d = FILL;
                else if (soil_f && dwell_done_q) state_d = air_f ? SPRINKLE : DRIP;
            end
            default: begin
                if (wb_s2_q == 2'b00)             state_d = FILL;
                else if (!soil_f && dwell_done_q) state_d = STANDBY;
            end
        endcase
    end

    always_comb begin
        dwell_d = dwell_q;
        if (state_d != state_q)      dwell_d = '0;
        else if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 8'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= FILL;
            dwell_q      <= '0;
            dwell_done_q <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            dwell_done_q <= (dwell_d == DWELL_MAX);
            alarm_q      <= (state_d == FILL) && soil_f;
        end
    end

    assign bus.state      = state_q;
    assign bus.alarm      = alarm_q;
    assign bus.dwell_done = dwell_done_q;
endmodule
